// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// flush, bubble masking, optional 2-entry skid and a stall counter.
module pipe_stage_reg #(
  parameter int WIDTH  = 32,
  parameter int INDEX  = 5,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [INDEX-1:0]  rd_in,
  input  logic [WIDTH-1:0]  data_a_in,
  input  logic [WIDTH-1:0]  data_b_in,
  input  logic              flush_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [INDEX-1:0]  rd_out,
  output logic [WIDTH-1:0]  data_a_out,
  output logic [WIDTH-1:0]  data_b_out,
  output logic [1:0]        occupancy_out,
  output logic [CNT_W-1:0]  stall_cnt_out
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [INDEX-1:0]  rd;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
  } ent_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ent_t main_q;
  ent_t skid_q;
  ent_t in_w;
  logic main_v;
  logic skid_v;
  logic accept;
  logic drain;

  assign in_w = '{
    ctrl: ctrl_in,
    rd:   rd_in,
    a:    data_a_in,
    b:    data_b_in
  };

  // Skid mode breaks the ready_in -> ready_out path.
  if (SKID != 0) begin : g_skid_rdy
    assign ready_out = ~skid_v;
  end else begin : g_pass_rdy
    assign ready_out = ready_in | ~main_v;
  end

  assign accept = valid_in & ready_out;
  assign drain  = main_v & ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_in) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (SKID != 0) begin
      if (drain) begin
        if (skid_v) begin
          main_q <= skid_q;
          skid_v <= 1'b0;
        end else if (accept) begin
          main_q <= in_w;
        end else begin
          main_v <= 1'b0;
        end
      end else if (accept) begin
        if (main_v) begin
          skid_q <= in_w;
          skid_v <= 1'b1;
        end else begin
          main_q <= in_w;
          main_v <= 1'b1;
        end
      end
    end else begin
      if (accept) begin
        main_q <= in_w;
        main_v <= 1'b1;
      end else if (drain) begin
        main_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stall_cnt_out <= '0;
    end else if (main_v && !ready_in &&
                 stall_cnt_out != CNT_MAX) begin
      stall_cnt_out <= stall_cnt_out + 1'b1;
    end
  end

  // Bubbles never carry write enables or an index.
  assign valid_out     = main_v;
  assign ctrl_out      = main_v ? main_q.ctrl : '0;
  assign rd_out        = main_v ? main_q.rd : '0;
  assign data_a_out    = main_q.a;
  assign data_b_out    = main_q.b;
  assign occupancy_out = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and pass-through instances share
// stimulus; each is checked against its own FIFO reference model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [1:0]  ctrl_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] data_a_in = '0;
  logic [31:0] data_b_in = '0;
  logic        flush_in = 1'b0;
  logic        ready_in = 1'b0;

  logic        ro0, vo0, ro1, vo1;
  logic [1:0]  co0, co1, oc0, oc1;
  logic [4:0]  rdo0, rdo1;
  logic [31:0] ao0, bo0, ao1, bo1;
  logic [1:0]  st0;
  logic [15:0] st1;

  int checks = 0;
  int failures = 0;

  pl_t q[2][$];
  pl_t last[2];
  int  cnt[2];
  int  cmax[2];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WIDTH(32), .INDEX(5), .CTRL_W(2), .SKID(1), .CNT_W(2)
  ) u0 (
    .clk_in(clk), .rst_in(rst_in),
    .valid_in(valid_in), .ready_out(ro0),
    .ctrl_in(ctrl_in), .rd_in(rd_in),
    .data_a_in(data_a_in), .data_b_in(data_b_in),
    .flush_in(flush_in),
    .valid_out(vo0), .ready_in(ready_in),
    .ctrl_out(co0), .rd_out(rdo0),
    .data_a_out(ao0), .data_b_out(bo0),
    .occupancy_out(oc0), .stall_cnt_out(st0)
  );

  pipe_stage_reg #(
    .WIDTH(32), .INDEX(5), .CTRL_W(2), .SKID(0), .CNT_W(16)
  ) u1 (
    .clk_in(clk), .rst_in(rst_in),
    .valid_in(valid_in), .ready_out(ro1),
    .ctrl_in(ctrl_in), .rd_in(rd_in),
    .data_a_in(data_a_in), .data_b_in(data_b_in),
    .flush_in(flush_in),
    .valid_out(vo1), .ready_in(ready_in),
    .ctrl_out(co1), .rd_out(rdo1),
    .data_a_out(ao1), .data_b_out(bo1),
    .occupancy_out(oc1), .stall_cnt_out(st1)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Skid stage is a depth-2 FIFO; pass-through is depth-1
  // that may replace its entry while draining.
  function automatic bit mrdy(int i);
    if (i == 0) return q[0].size() < 2;
    return ready_in || q[1].size() == 0;
  endfunction

  initial begin
    cmax[0] = 3;
    cmax[1] = 65535;
    cnt[0] = 0;
    cnt[1] = 0;
    last[0] = '0;
    last[1] = '0;
  end

  always @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 2; i++) begin
        q[i].delete();
        cnt[i] = 0;
        last[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit acc;
        bit drn;
        pl_t w;
        w = '{ctrl_in, rd_in, data_a_in, data_b_in};
        acc = valid_in && mrdy(i);
        drn = q[i].size() > 0 && ready_in;
        if (q[i].size() > 0 && !ready_in && cnt[i] < cmax[i])
          cnt[i]++;
        if (flush_in) begin
          q[i].delete();
        end else begin
          if (drn) void'(q[i].pop_front());
          if (acc) q[i].push_back(w);
        end
        if (q[i].size() > 0) last[i] = q[i][0];
      end
    end
  end

  task automatic mon(int i, logic v, logic r,
                     logic [1:0] occ, logic [15:0] st,
                     logic [1:0] c, logic [4:0] rd,
                     logic [31:0] a, logic [31:0] b);
    int n;
    pl_t h;
    n = q[i].size();
    h = (n > 0) ? q[i][0] : '0;
    chk($sformatf("u%0d.valid", i), 64'(v), 64'(n > 0));
    chk($sformatf("u%0d.ready", i), 64'(r), 64'(mrdy(i)));
    chk($sformatf("u%0d.occ", i), 64'(occ), 64'(n));
    chk($sformatf("u%0d.stall", i), 64'(st), 64'(cnt[i]));
    chk($sformatf("u%0d.ctrl", i), 64'(c), 64'(h.ctrl));
    chk($sformatf("u%0d.rd", i), 64'(rd), 64'(h.rd));
    chk($sformatf("u%0d.a", i), 64'(a), 64'(last[i].a));
    chk($sformatf("u%0d.b", i), 64'(b), 64'(last[i].b));
  endtask

  always @(negedge clk) begin
    mon(0, vo0, ro0, oc0, 16'(st0), co0, rdo0, ao0, bo0);
    mon(1, vo1, ro1, oc1, st1, co1, rdo1, ao1, bo1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(logic [4:0] rd, logic [31:0] a,
                     logic [31:0] b);
    valid_in = 1'b1;
    ctrl_in = 2'b01;
    rd_in = rd;
    data_a_in = a;
    data_b_in = b;
  endtask

  initial begin
    tick();
    tick();
    chk("rst.valid", 64'(vo0), 64'(0));
    chk("rst.ready", 64'(ro0), 64'(1));
    chk("rst.occ", 64'(oc0), 64'(0));
    rst_in = 1'b1;

    // passthrough
    ready_in = 1'b1;
    put(5'd7, 32'h11, 32'hAB);
    tick();
    valid_in = 1'b0;
    chk("pt.valid", 64'(vo0), 64'(1));
    chk("pt.rd", 64'(rdo0), 64'(7));
    chk("pt.b", 64'(bo0), 64'hAB);
    tick();
    chk("pt.bub_valid", 64'(vo0), 64'(0));
    chk("pt.bub_ctrl", 64'(co0), 64'(0));
    chk("pt.bub_rd", 64'(rdo0), 64'(0));

    // throughput
    for (int k = 1; k <= 8; k++) begin
      put(5'(k), 32'(k * 3), 32'(k * 5));
      tick();
      chk("tp.valid", 64'(vo0), 64'(1));
      chk("tp.rd", 64'(rdo0), 64'(k));
      chk("tp.occ_le1", 64'(oc0 <= 2'd1), 64'(1));
    end
    valid_in = 1'b0;
    tick();
    tick();

    // skid fill and drain
    ready_in = 1'b0;
    put(5'd10, 32'hA0, 32'hA1);
    tick();
    put(5'd11, 32'hB0, 32'hB1);
    tick();
    valid_in = 1'b0;
    chk("skid.occ", 64'(oc0), 64'(2));
    chk("skid.ready", 64'(ro0), 64'(0));
    chk("skid.rdA", 64'(rdo0), 64'(10));
    tick();
    chk("skid.holdA", 64'(ao0), 64'hA0);
    ready_in = 1'b1;
    tick();
    chk("skid.rdB", 64'(rdo0), 64'(11));
    chk("skid.ready_back", 64'(ro0), 64'(1));
    tick();
    chk("skid.empty", 64'(vo0), 64'(0));

    // flush with full skid
    ready_in = 1'b0;
    put(5'd20, 32'hC0, 32'hC1);
    tick();
    put(5'd21, 32'hD0, 32'hD1);
    tick();
    chk("fl.occ2", 64'(oc0), 64'(2));
    put(5'd12, 32'hCC, 32'hCD);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    chk("fl.valid", 64'(vo0), 64'(0));
    chk("fl.occ", 64'(oc0), 64'(0));
    chk("fl.ready", 64'(ro0), 64'(1));
    ready_in = 1'b1;
    tick();
    tick();

    // stall counter saturation
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    ready_in = 1'b0;
    put(5'd3, 32'h3, 32'h33);
    tick();
    valid_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("stall.seq", 64'(st0), 64'((k > 3) ? 3 : k));
    end
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("stall.post_flush", 64'(st0), 64'(3));

    // async reset mid-stream
    put(5'd4, 32'h44, 32'h45);
    tick();
    put(5'd5, 32'h55, 32'h56);
    tick();
    valid_in = 1'b0;
    chk("ar.occ2", 64'(oc0), 64'(2));
    #2;
    rst_in = 1'b0;
    #1;
    chk("ar.valid", 64'(vo0), 64'(0));
    chk("ar.a", 64'(ao0), 64'(0));
    chk("ar.b", 64'(bo0), 64'(0));
    chk("ar.occ", 64'(oc0), 64'(0));
    chk("ar.stall", 64'(st0), 64'(0));
    #1;
    rst_in = 1'b1;
    ready_in = 1'b1;
    tick();
    tick();
    chk("ar.no_stale", 64'(vo0), 64'(0));

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      valid_in = ($urandom % 4) != 0;
      ctrl_in = 2'($urandom);
      rd_in = 5'($urandom);
      data_a_in = $urandom;
      data_b_in = $urandom;
      ready_in = ($urandom % 10) < 7;
      flush_in = ($urandom % 32) == 0;
      tick();
    end
    valid_in = 1'b0;
    flush_in = 1'b0;
    ready_in = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
